times_table_init: RTL and testbench

TIMES_TABLE_INIT -- requirements
Module: times_table_init

---
 rtl/times_table_init_pkg.sv | 29 ++
 rtl/times_table_init_if.sv | 40 ++++
 rtl/times_table_init.sv | 200 ++++++++++++++++++++
 tb/tb_times_table_init.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/times_table_init_pkg.sv
// ---------------------------------------------------------------------------
// times_table_init_pkg
// Shared definitions for the times-table memory. The write-side initialiser
// (times_table_init) and the read-side multiplier both use these, so the
// table size, the AXI response code and the product rule stay in one place.
//   TABLE_ENTRIES : number of entries in the 8x8 table
//   AXI_RESP_OKAY : AXI4-lite OKAY response code
//   tt_state_e    : fill sequencer states
//   tt_product    : product of the two 3-bit operands packed into an index
// ---------------------------------------------------------------------------
package times_table_init_pkg;

    localparam int         TABLE_ENTRIES = 64;
    localparam int         INDEX_W       = 6;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } tt_state_e;

    // The index is {a[2:0], b[2:0]}; the product always fits in 6 bits.
    function automatic logic [INDEX_W-1:0] tt_product(input logic [INDEX_W-1:0] index);
        return {3'd0, index[5:3]} * {3'd0, index[2:0]};
    endfunction

endpackage

// File: rtl/times_table_init_if.sv
// ---------------------------------------------------------------------------
// times_table_init_if
// AXI4-lite write-only bus between the times-table initialiser (master) and
// the table memory (slave).
//   awaddr/awvalid/awready : write-address channel
//   wdata/wstrb/wvalid/wready : write-data channel
//   bresp/bvalid/bready    : write-response channel
// ---------------------------------------------------------------------------
interface times_table_init_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/times_table_init.sv
// ---------------------------------------------------------------------------
// times_table_init
// Fills the 64-entry times table in an AXI4-lite slave with a*b, one entry
// per AW/W/B transaction, index {a,b} ascending from 0 to 63.
// Parameters:
//   BASE_ADDR  : byte address of entry 0 in the slave
//   AUTO_START : when nonzero, a fill starts on the first clock after reset
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : one-cycle fill request (ignored while busy)
//   m_axi      : AXI4-lite write master
//   busy       : fill in progress
//   done       : sticky, last entry acknowledged
//   error      : sticky, a non-OKAY response was seen during this fill
// ---------------------------------------------------------------------------
module times_table_init
    import times_table_init_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          AUTO_START = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    times_table_init_if.master  m_axi,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(TABLE_ENTRIES - 1);

    tt_state_e          state_q, state_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               aw_ok_q, aw_ok_d;
    logic               w_ok_q, w_ok_d;
    logic               bready_q, bready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [31:0]        awaddr_q, awaddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               auto_pending_q;

    logic               fill_req;
    logic               aw_hs;
    logic               w_hs;
    logic               aw_done;
    logic               w_done;

    function automatic logic [31:0] entry_addr(input logic [INDEX_W-1:0] index);
        return BASE_ADDR + {24'd0, index, 2'b00};
    endfunction

    function automatic logic [31:0] entry_data(input logic [INDEX_W-1:0] index);
        return {26'd0, tt_product(index)};
    endfunction

    // The auto-start request is armed by reset and consumed by the first
    // clock after release, so it fires exactly once per reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_pending_q <= (AUTO_START != 0);
        end else begin
            auto_pending_q <= 1'b0;
        end
    end

    // State register of the fill sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output. AW and W are
    // tracked separately: each valid drops right after its own handshake and
    // the aw_ok/w_ok flags remember which channels are finished, so the two
    // channels may complete in either order before moving to RESP.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_ok_d   = aw_ok_q;
        w_ok_d    = w_ok_q;
        bready_d  = bready_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;

        fill_req  = start || auto_pending_q;
        aw_hs     = awvalid_q && m_axi.awready;
        w_hs      = wvalid_q && m_axi.wready;
        aw_done   = aw_ok_q || aw_hs;
        w_done    = w_ok_q || w_hs;

        case (state_q)
            IDLE, DONE: begin
                if (fill_req) begin
                    state_d   = WRITE;
                    index_d   = '0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    awaddr_d  = entry_addr('0);
                    wdata_d   = entry_data('0);
                end
            end
            WRITE: begin
                if (aw_done && w_done) begin
                    state_d   = RESP;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    aw_ok_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    bready_d  = 1'b1;
                end else begin
                    awvalid_d = awvalid_q && !aw_hs;
                    wvalid_d  = wvalid_q && !w_hs;
                    aw_ok_d   = aw_done;
                    w_ok_d    = w_done;
                end
            end
            RESP: begin
                if (m_axi.bvalid && bready_q) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != AXI_RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    if (index_q == LAST_INDEX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = WRITE;
                        index_d   = index_q + 1'b1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = entry_addr(index_q + 1'b1);
                        wdata_d   = entry_data(index_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath registers; reset abandons any fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            awaddr_q  <= BASE_ADDR;
            wdata_q   <= '0;
        end else begin
            index_q   <= index_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_ok_q   <= aw_ok_d;
            w_ok_q    <= w_ok_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_times_table_init.sv
// ---------------------------------------------------------------------------
// tb_times_table_init
// Bench for times_table_init with BASE_ADDR=0 and AUTO_START=1. A slave model
// with configurable random ready/response delays logs every transaction; the
// main process compares the log against the table rule addr=i*4, data=a*b.
// ---------------------------------------------------------------------------
module tb_times_table_init;
    import times_table_init_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic error;

    times_table_init_if bus ();

    times_table_init #(
        .BASE_ADDR  (BASE),
        .AUTO_START (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m_axi (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // slave configuration (written by the main process only)
    int aw_max = 0;
    int w_max = 0;
    int b_max = 0;
    int slow_entry = -1;
    int err_entry = -1;

    // slave state and transaction log (written by the slave process only)
    int aw_wait, w_wait, b_wait, aw_first;
    bit aw_seen, w_seen, got_aw, got_w, b_fire, aw_pend, w_pend, prev_busy;
    logic [31:0] aw_pend_addr, w_pend_data;
    int b_count, aw_count, w_count, aw_total, aw_dup, w_dup, stable_viol, strb_bad, w_hold;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic [31:0] mem [64];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference model: the table rule written directly
    function automatic logic [31:0] exp_addr(input int i);
        return BASE + 32'(i * 4);
    endfunction

    function automatic logic [31:0] exp_data(input int i);
        return 32'((i / 8) * (i % 8));
    endfunction

    function automatic logic [31:0] read_mult(input int a, input int b);
        return mem[a * 8 + b];
    endfunction

    task automatic slave_reset();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        aw_seen = 0; w_seen = 0; got_aw = 0; got_w = 0; b_fire = 0;
        aw_pend = 0; w_pend = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; aw_first = 0;
    endtask

    task automatic fill_clear();
        b_count = 0; aw_count = 0; w_count = 0; aw_dup = 0; w_dup = 0;
        stable_viol = 0; strb_bad = 0; w_hold = 0;
        for (int i = 0; i < 64; i++) begin
            log_addr[i] = 32'hDEAD_BEEF;
            log_data[i] = 32'hDEAD_BEEF;
        end
    endtask

    // AXI slave model: acts on the falling edge, deciding readies and noting
    // which handshakes will complete at the next rising edge.
    initial begin
        aw_total = 0;
        prev_busy = 0;
        slave_reset();
        fill_clear();
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (rst) begin
                slave_reset();
                prev_busy = 0;
            end else begin
                if (busy && !prev_busy) fill_clear();
                prev_busy = busy;
                if (b_fire) begin
                    bus.bvalid = 1'b0;
                    bus.bresp  = 2'b00;
                    b_fire = 0;
                end
                if (aw_pend && (!bus.awvalid || bus.awaddr !== aw_pend_addr)) stable_viol++;
                if (w_pend && (!bus.wvalid || bus.wdata !== w_pend_data)) stable_viol++;
                if (bus.awvalid && got_aw) aw_dup++;
                if (bus.wvalid && got_w) w_dup++;
                if (got_aw && got_w && !bus.bvalid) begin
                    if (b_wait == 0) begin
                        bus.bvalid = 1'b1;
                        bus.bresp  = (b_count == err_entry) ? 2'b10 : 2'b00;
                        got_aw = 0;
                        got_w  = 0;
                    end else begin
                        b_wait--;
                    end
                end
                bus.awready = 1'b0;
                if (bus.awvalid && !got_aw) begin
                    if (!aw_seen) begin
                        aw_seen  = 1;
                        aw_wait  = $urandom_range(0, aw_max);
                        aw_first = aw_wait;
                    end
                    if (aw_wait == 0) bus.awready = 1'b1;
                    else aw_wait--;
                end
                bus.wready = 1'b0;
                if (bus.wvalid && !got_w) begin
                    if (!w_seen) begin
                        w_seen = 1;
                        w_wait = (b_count == slow_entry) ? aw_first + 3 : $urandom_range(0, w_max);
                    end
                    if (w_wait == 0) bus.wready = 1'b1;
                    else w_wait--;
                end
                if (bus.wvalid && !bus.wready && b_count == slow_entry) w_hold++;
                aw_pend = 0;
                if (bus.awvalid && bus.awready) begin
                    got_aw = 1; aw_seen = 0; aw_count++; aw_total++;
                    b_wait = $urandom_range(0, b_max);
                    if (b_count < 64) log_addr[b_count] = bus.awaddr;
                end else if (bus.awvalid) begin
                    aw_pend = 1; aw_pend_addr = bus.awaddr;
                end
                w_pend = 0;
                if (bus.wvalid && bus.wready) begin
                    got_w = 1; w_seen = 0; w_count++;
                    if (bus.wstrb !== 4'hF) strb_bad++;
                    if (b_count < 64) log_data[b_count] = bus.wdata;
                end else if (bus.wvalid) begin
                    w_pend = 1; w_pend_data = bus.wdata;
                end
                if (bus.bvalid && bus.bready) begin
                    b_fire = 1;
                    if (b_count < 64) begin
                        logic [31:0] a_tmp;
                        a_tmp = log_addr[b_count];
                        mem[a_tmp[7:2]] = log_data[b_count];
                    end
                    b_count++;
                end
            end
        end
    end

    task automatic apply_stimulus_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        check_output("fill_done", done, 1);
    endtask

    task automatic check_fill(input string tag, input logic exp_err);
        for (int i = 0; i < 64; i++) begin
            check_output($sformatf("%s_addr[%0d]", tag, i), log_addr[i], exp_addr(i));
            check_output($sformatf("%s_data[%0d]", tag, i), log_data[i], exp_data(i));
        end
        check_output({tag, "_b_count"}, b_count, 64);
        check_output({tag, "_aw_count"}, aw_count, 64);
        check_output({tag, "_w_count"}, w_count, 64);
        check_output({tag, "_aw_dup"}, aw_dup, 0);
        check_output({tag, "_w_dup"}, w_dup, 0);
        check_output({tag, "_stable"}, stable_viol, 0);
        check_output({tag, "_wstrb"}, strb_bad, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_error"}, error, exp_err);
    endtask

    initial begin
        int cycles;
        int snap;
        rst = 1'b1;
        start = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_error", error, 0);
        check_output("rst_awvalid", bus.awvalid, 0);
        check_output("rst_wvalid", bus.wvalid, 0);
        check_output("rst_bready", bus.bready, 0);
        check_output("rst_awaddr", bus.awaddr, BASE);
        check_output("rst_wdata", bus.wdata, 0);

        // auto-start fill with a zero-wait slave
        $display("[TB] auto-start fill, zero-wait slave");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        wait_done(cycles);
        check_output("auto_cycles", cycles, 128);
        check_fill("auto", 1'b0);
        check_output("readback_7x6", read_mult(7, 6), 32'(7 * 6));

        // randomized ready/response delays
        $display("[TB] randomized slave delays");
        aw_max = 3; w_max = 3; b_max = 3;
        apply_stimulus_start();
        check_output("rand_busy", busy, 1);
        check_output("rand_done_clr", done, 0);
        wait_done(cycles);
        check_output("rand_min_cycles", (cycles >= 128) ? 1 : 0, 1);
        check_fill("rand", 1'b0);

        // slow W on entry 5
        $display("[TB] wready delayed on entry 5");
        aw_max = 0; w_max = 0; b_max = 0; slow_entry = 5;
        apply_stimulus_start();
        wait_done(cycles);
        check_output("slow_cycles", cycles, 128 + 3);
        check_output("slow_w_hold", w_hold, 3);
        check_fill("slow", 1'b0);
        slow_entry = -1;

        // error response on entry 10
        $display("[TB] SLVERR on entry 10");
        err_entry = 10;
        apply_stimulus_start();
        wait_done(cycles);
        check_output("err_cycles", cycles, 128);
        check_fill("err", 1'b1);
        check_output("err_done", done, 1);
        err_entry = -1;

        // new start clears flags; start during the fill is ignored
        $display("[TB] restart, then start pulsed mid-fill");
        apply_stimulus_start();
        check_output("restart_error_clr", error, 0);
        check_output("restart_done_clr", done, 0);
        check_output("restart_busy", busy, 1);
        repeat (40) @(posedge clk);
        apply_stimulus_start();
        wait_done(cycles);
        check_output("midstart_cycles", 41 + cycles, 128);
        check_fill("midstart", 1'b0);

        // reset during entry 20, then auto restart from entry 0
        $display("[TB] reset during entry 20");
        apply_stimulus_start();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (b_count == 20) break;
        end
        check_output("reach_entry20", b_count, 20);
        @(posedge clk);
        #2;
        check_output("entry20_awvalid", bus.awvalid, 1);
        check_output("entry20_awaddr", bus.awaddr, exp_addr(20));
        snap = aw_total;
        rst = 1'b1;
        #1;
        check_output("async_awvalid", bus.awvalid, 0);
        check_output("async_wvalid", bus.wvalid, 0);
        check_output("async_bready", bus.bready, 0);
        check_output("async_busy", busy, 0);
        check_output("async_awaddr", bus.awaddr, BASE);
        repeat (3) @(negedge clk);
        #1;
        check_output("rst_hold_no_aw", aw_total, snap);
        check_output("rst_hold_awvalid", bus.awvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        wait_done(cycles);
        check_output("rerun_cycles", cycles, 128);
        check_fill("rerun", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
